// File: rtl/ram_sp_param.sv
// ram_sp_param: parametrised single-port synchronous RAM.
//
// Byte-lane write enables, selectable read-during-write behaviour, an
// optional second output register, and a clear engine that fills the
// array with CLEAR_VAL after reset while holding off user accesses.
//
// Ports
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset (does not touch the array)
//   en_i      access request, ignored while busy_o=1
//   we_i      per-byte write enable, bit i covers din_i[8i+7:8i]
//   addr_i    word address
//   din_i     write data
//   dout_o    read data, held between updates
//   dvalid_o  one-cycle strobe, dout_o updated this cycle
//   busy_o    clear engine running
//
// State    | meaning
// S_CLEAR  | writing CLEAR_VAL to address clr_cnt_q, user accesses dropped
// S_READY  | normal read/write service
module ram_sp_param #(
    parameter int                 DATA_W       = 8,
    parameter int                 ADDR_W       = 8,
    parameter int                 DEPTH        = 2**ADDR_W,
    parameter int                 OUT_REG      = 0,
    parameter int                 WRITE_MODE   = 0,
    parameter int                 CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VAL    = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DATA_W/8-1:0]  we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    din_i,
    output logic [DATA_W-1:0]    dout_o,
    output logic                 dvalid_o,
    output logic                 busy_o
);

    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH = 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               acc, wr, in_range, upd;
    logic [DATA_W-1:0]  rdata, merged, upd_data;
    logic               s_valid;
    logic [DATA_W-1:0]  s_data;
    logic [DATA_W-1:0]  dout_q;
    logic               dvalid_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = S_READY;
            end
        end
    end

    // FSM outputs
    always_comb begin
        busy_o = (state_q == S_CLEAR);
    end

    // Access decode and read-during-write data selection
    always_comb begin
        acc      = (state_q == S_READY) && en_i;
        wr       = acc && (|we_i);
        in_range = ({1'b0, addr_i} < DEPTH_X);
        rdata    = in_range ? mem[addr_i] : '0;
        merged   = rdata;
        for (int i = 0; i < NB; i++) begin
            if (we_i[i]) begin
                merged[8*i +: 8] = din_i[8*i +: 8];
            end
        end
        // NO_CHANGE writes leave dout untouched and raise no strobe.
        upd      = acc && !(wr && (WRITE_MODE == 2));
        if (!in_range) begin
            upd_data = '0;
        end else if (wr && (WRITE_MODE == 1)) begin
            upd_data = merged;
        end else begin
            upd_data = rdata;
        end
    end

    // Array: no reset, and nothing is written on a reset edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_CLEAR) begin
                mem[clr_cnt_q] <= CLEAR_VAL;
            end else if (wr && in_range) begin
                mem[addr_i] <= merged;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_pipe
            logic               s1_valid_q;
            logic [DATA_W-1:0]  s1_data_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= upd;
                    if (upd) begin
                        s1_data_q <= upd_data;
                    end
                end
            end

            assign s_valid = s1_valid_q;
            assign s_data  = s1_data_q;
        end else begin : g_direct
            assign s_valid = upd;
            assign s_data  = upd_data;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= s_valid;
            if (s_valid) begin
                dout_q <= s_data;
            end
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param. Four instances with independent inputs:
//   0: OUT_REG=0, READ_FIRST,  clear on reset
//   1: OUT_REG=1, WRITE_FIRST, clear on reset
//   2: OUT_REG=0, NO_CHANGE,   no clear on reset
//   3: DEPTH=12,  OUT_REG=0, READ_FIRST, clear on reset
module tb_ram_sp_param;

    logic        clk;
    logic        rst    [4];
    logic        en     [4];
    logic [1:0]  we     [4];
    logic [3:0]  addr   [4];
    logic [15:0] din    [4];
    logic [15:0] dout   [4];
    logic        dvalid [4];
    logic        busy   [4];

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .WRITE_MODE(0), .CLEAR_ON_RST(1)) u0 (
        .clk_i(clk), .rst_i(rst[0]), .en_i(en[0]), .we_i(we[0]), .addr_i(addr[0]), .din_i(din[0]),
        .dout_o(dout[0]), .dvalid_o(dvalid[0]), .busy_o(busy[0]));

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(1), .WRITE_MODE(1), .CLEAR_ON_RST(1)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .en_i(en[1]), .we_i(we[1]), .addr_i(addr[1]), .din_i(din[1]),
        .dout_o(dout[1]), .dvalid_o(dvalid[1]), .busy_o(busy[1]));

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .OUT_REG(0), .WRITE_MODE(2), .CLEAR_ON_RST(0)) u2 (
        .clk_i(clk), .rst_i(rst[2]), .en_i(en[2]), .we_i(we[2]), .addr_i(addr[2]), .din_i(din[2]),
        .dout_o(dout[2]), .dvalid_o(dvalid[2]), .busy_o(busy[2]));

    ram_sp_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12), .OUT_REG(0), .WRITE_MODE(0), .CLEAR_ON_RST(1)) u3 (
        .clk_i(clk), .rst_i(rst[3]), .en_i(en[3]), .we_i(we[3]), .addr_i(addr[3]), .din_i(din[3]),
        .dout_o(dout[3]), .dvalid_o(dvalid[3]), .busy_o(busy[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [15:0] d, input logic [1:0] w);
        en[k] = 1'b1; we[k] = w; addr[k] = a; din[k] = d;
        tick();
        en[k] = 1'b0; we[k] = 2'b00;
    endtask

    task automatic rd(input int k, input logic [3:0] a);
        en[k] = 1'b1; we[k] = 2'b00; addr[k] = a;
        tick();
        en[k] = 1'b0;
    endtask

    // Counts consecutive busy samples from now, bounded.
    task automatic busy_len(input int k, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy[k]) break;
            n++;
            addr[k] = 4'(i);
            tick();
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'hC000 | 16'(i * 17);
    endfunction

    initial begin
        int n;
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; en[k] = 1'b0; we[k] = 2'b00; addr[k] = 4'h0; din[k] = 16'h0000;
        end
        idle(2);
        chk("rst_dout0",   32'(dout[0]), 32'h0);
        chk("rst_dvalid0", 32'(dvalid[0]), 32'h0);
        chk("rst_busy0",   32'(busy[0]), 32'h1);
        chk("rst_busy1",   32'(busy[1]), 32'h1);
        chk("rst_busy2",   32'(busy[2]), 32'h0);
        chk("rst_dvalid1", 32'(dvalid[1]), 32'h0);
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;

        // Clear length, with writes attempted on u0 while busy.
        en[0] = 1'b1; we[0] = 2'b11; din[0] = 16'hFFFF;
        busy_len(0, n);
        en[0] = 1'b0; we[0] = 2'b00;
        chk("clear_len", 32'(n), 32'd16);
        chk("busy1_done", 32'(busy[1]), 32'h0);
        chk("busy3_done", 32'(busy[3]), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd(0, 4'(i));
            chk("clr_rd_data",  32'(dout[0]), 32'h0);
            chk("clr_rd_valid", 32'(dvalid[0]), 32'h1);
        end
        tick();
        chk("idle_dvalid0", 32'(dvalid[0]), 32'h0);

        // u0: byte enables, latency 1
        wr(0, 4'd3, 16'hABCD, 2'b11);
        wr(0, 4'd3, 16'h1200, 2'b10);
        rd(0, 4'd3);
        chk("be_data0",  32'(dout[0]), 32'h12CD);
        chk("be_valid0", 32'(dvalid[0]), 32'h1);
        tick();
        chk("be_pulse0", 32'(dvalid[0]), 32'h0);
        chk("be_hold0",  32'(dout[0]), 32'h12CD);

        // u0: READ_FIRST
        wr(0, 4'd5, 16'h1111, 2'b11);
        wr(0, 4'd5, 16'h2222, 2'b11);
        chk("rf_data",  32'(dout[0]), 32'h1111);
        chk("rf_valid", 32'(dvalid[0]), 32'h1);
        rd(0, 4'd5);
        chk("rf_after", 32'(dout[0]), 32'h2222);

        // u1: byte enables, latency 2
        wr(1, 4'd3, 16'hABCD, 2'b11);
        wr(1, 4'd3, 16'h1200, 2'b10);
        idle(3);
        rd(1, 4'd3);
        chk("be_lat1",   32'(dvalid[1]), 32'h0);
        tick();
        chk("be_data1",  32'(dout[1]), 32'h12CD);
        chk("be_valid1", 32'(dvalid[1]), 32'h1);
        tick();
        chk("be_pulse1", 32'(dvalid[1]), 32'h0);

        // u1: WRITE_FIRST, then read of same address on the next edge
        wr(1, 4'd5, 16'h1111, 2'b11);
        idle(3);
        wr(1, 4'd5, 16'h2222, 2'b11);
        chk("wf_lat",   32'(dvalid[1]), 32'h0);
        rd(1, 4'd5);
        chk("wf_data",  32'(dout[1]), 32'h2222);
        chk("wf_valid", 32'(dvalid[1]), 32'h1);
        tick();
        chk("raw_data",  32'(dout[1]), 32'h2222);
        chk("raw_valid", 32'(dvalid[1]), 32'h1);
        tick();
        chk("raw_pulse", 32'(dvalid[1]), 32'h0);

        // u1: back-to-back streaming reads
        for (int i = 0; i < 16; i++) wr(1, 4'(i), pat(i), 2'b11);
        idle(3);
        en[1] = 1'b1; we[1] = 2'b00; addr[1] = 4'd0;
        for (int j = 0; j < 18; j++) begin
            tick();
            if (j + 1 < 16) addr[1] = 4'(j + 1);
            else en[1] = 1'b0;
            if (j == 0) begin
                chk("str_lat", 32'(dvalid[1]), 32'h0);
            end else if (j <= 16) begin
                chk("str_data",  32'(dout[1]), 32'(pat(j - 1)));
                chk("str_valid", 32'(dvalid[1]), 32'h1);
            end else begin
                chk("str_end", 32'(dvalid[1]), 32'h0);
            end
        end

        // u1: reset discards an in-flight read
        en[1] = 1'b1; addr[1] = 4'd3;
        tick();
        en[1] = 1'b0; rst[1] = 1'b1;
        tick();
        chk("flush_valid", 32'(dvalid[1]), 32'h0);
        chk("flush_dout",  32'(dout[1]), 32'h0);
        rst[1] = 1'b0;

        // u2: NO_CHANGE, no clear
        wr(2, 4'd5, 16'h1111, 2'b11);
        chk("nc_wvalid0", 32'(dvalid[2]), 32'h0);
        rd(2, 4'd5);
        chk("nc_rd0", 32'(dout[2]), 32'h1111);
        wr(2, 4'd5, 16'h2222, 2'b11);
        chk("nc_hold",   32'(dout[2]), 32'h1111);
        chk("nc_wvalid", 32'(dvalid[2]), 32'h0);
        rd(2, 4'd5);
        chk("nc_rd1", 32'(dout[2]), 32'h2222);
        wr(2, 4'd7, 16'h5A5A, 2'b11);
        rst[2] = 1'b1;
        tick();
        chk("nc_rst_dout", 32'(dout[2]), 32'h0);
        chk("nc_rst_busy", 32'(busy[2]), 32'h0);
        rst[2] = 1'b0;
        tick();
        chk("nc_busy", 32'(busy[2]), 32'h0);
        rd(2, 4'd7);
        chk("retain_data",  32'(dout[2]), 32'h5A5A);
        chk("retain_valid", 32'(dvalid[2]), 32'h1);

        // u3: DEPTH=12 range handling
        wr(3, 4'd13, 16'h7777, 2'b11);
        rd(3, 4'd13);
        chk("oor_data",  32'(dout[3]), 32'h0);
        chk("oor_valid", 32'(dvalid[3]), 32'h1);
        wr(3, 4'd11, 16'hBEEF, 2'b11);
        rd(3, 4'd11);
        chk("edge_data",  32'(dout[3]), 32'hBEEF);
        chk("edge_valid", 32'(dvalid[3]), 32'h1);

        // u0: reset during clear at address 7 restarts the sweep
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        idle(7);
        chk("mid_busy", 32'(busy[0]), 32'h1);
        rst[0] = 1'b1;
        tick();
        chk("mid_rst_dout",   32'(dout[0]), 32'h0);
        chk("mid_rst_dvalid", 32'(dvalid[0]), 32'h0);
        rst[0] = 1'b0;
        busy_len(0, n);
        chk("restart_len", 32'(n), 32'd16);
        rd(0, 4'd3);
        chk("reclr_3", 32'(dout[0]), 32'h0);
        rd(0, 4'd5);
        chk("reclr_5", 32'(dout[0]), 32'h0);
        chk("reclr_valid", 32'(dvalid[0]), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sp_param.md
# ram_sp_param

Parametrised single-port synchronous RAM; the next generation of the team's fixed 8x256 core-generated RAM wrapper. Adds configurable data width, address width and depth, per-byte write enables, selectable read-during-write mode, an optional output pipeline register with a valid strobe, and a reset-driven clear engine that zeroes the array. Sits between datapath/controller blocks and storage anywhere the lab designs need a scratch or lookup memory.

## Interface
- DATA_W, 8: word width in bits; multiple of 8; NB = DATA_W/8 byte lanes
- ADDR_W, 8: address width
- DEPTH, 2**ADDR_W: number of words; 1 <= DEPTH <= 2**ADDR_W
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2
- WRITE_MODE, 0: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- CLEAR_ON_RST, 1: 1 = zero the array after reset; 0 = contents retained across reset
- CLEAR_VAL, 0: DATA_W value written by the clear engine

- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- EN  in  1  access request; ignored while Busy=1
- WE  in  NB  per-byte write enable; bit i covers Din[8i+7:8i]; used only when EN=1
- Addr  in  ADDR_W  word address
- Din  in  DATA_W  write data
- Dout  out  DATA_W  read data; holds its value between updates
- Dvalid  out  1  one-cycle pulse, Dout updated this cycle
- Busy  out  1  clear engine running; user accesses dropped

## Operation
- Reset (RST=1 at an edge): Dout=0, Dvalid=0, pipeline stages cleared, clear counter=0; state=CLEAR with Busy=1 if CLEAR_ON_RST=1, else state=READY with Busy=0. Array untouched by RST itself.
- FSM states: CLEAR, READY.
- CLEAR: each edge writes CLEAR_VAL (all lanes) to address = counter, counter+1; at the edge writing DEPTH-1 -> READY, Busy=0. EN/WE ignored, Dvalid=0. RST during CLEAR restarts from address 0.
- READY: accepted access = EN=1 at an edge.
  - Read (WE=0): Dout <= mem[Addr].
  - Write (WE!=0): lanes with WE[i]=1 take Din bytes; other lanes unchanged. Dout per WRITE_MODE: READ_FIRST = pre-write word; WRITE_FIRST = merged post-write word; NO_CHANGE = Dout held, no Dvalid.
  - EN=0: no array change, Dout held, Dvalid=0.
- Out-of-range (Addr >= DEPTH): write dropped; read returns 0 with Dvalid=1.
- Dvalid=1 exactly for each accepted access that updates Dout, aligned with the update.
- RST in READY: in-flight pipeline data discarded, Dvalid=0 next cycle.

## Timing
- OUT_REG=0: access at edge n -> Dout/Dvalid valid after edge n (latency 1).
- OUT_REG=1: stage-1 after edge n, Dout/Dvalid after edge n+1 (latency 2); fully pipelined, one access per cycle, back-to-back results on consecutive cycles.
- Clear: taking the first edge with RST=0 as edge 0, addresses 0..DEPTH-1 written at edges 0..DEPTH-1; Busy=0 after edge DEPTH-1; first user access accepted at edge DEPTH.
- Write followed by read of same address on next edge returns new data (no hazard window), both OUT_REG values.
- Dout and Dvalid are registered outputs; no combinational path from inputs.

## Test plan
- DATA_W=16, ADDR_W=4, CLEAR_ON_RST=1: pulse RST one cycle -> Busy=1 for exactly 16 cycles; reads of all 16 addresses afterwards return 0x0000; EN during Busy leaves memory unchanged.
- Byte enables: write 0xABCD to addr 3 (WE=11), then 0x1200 with WE=10 -> read addr 3 returns 0x12CD, Dvalid one cycle, latency 1 (OUT_REG=0) / 2 (OUT_REG=1).
- Read-during-write on addr 5 holding 0x1111, write 0x2222 WE=11: READ_FIRST Dout=0x1111 Dvalid=1; WRITE_FIRST Dout=0x2222 Dvalid=1; NO_CHANGE Dout held, Dvalid=0.
- Back-to-back reads addrs 0..15 with OUT_REG=1 -> 16 consecutive Dvalid pulses, data in address order, first two cycles after first EN.
- RST asserted at clear address 7 -> clear restarts at 0, Busy stays high 16 more cycles; CLEAR_ON_RST=0 variant: data 0x5A5A written before RST still read back after RST, Busy never high.
- DEPTH=12, ADDR_W=4: write addr 13 then read addr 13 -> read returns 0x0000, Dvalid=1; addr 11 boundary write/read returns written value.
